// File: rtl/data_mem_resp.sv
// Load/store target: one request at a time, programmable wait states, byte-lane RAM,
// sign/zero-extended loads and illegal-request flagging with registered outputs.
module data_mem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_w_i,
    input  logic        res_w_i_l,
    input  logic [31:0] mem_addr_w_i,
    input  logic [31:0] mem_data_w_i,
    input  logic        mem_wr_w_i_h,
    input  logic        mem_rd_w_i_h,
    input  logic [2:0]  mem_size_w_i,
    output logic [31:0] mem_data_w_o,
    output logic        mem_ready_w_o_h,
    output logic        mem_err_w_o_h
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_size;
    logic        r_rd;
    logic        r_wr;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic                  w_size_ok;
    logic                  w_align_ok;
    logic                  w_range_ok;
    logic                  w_legal;
    logic [3:0]            w_lane_sel;
    logic [3:0]            w_we;
    logic [7:0]            w_wlane   [4];
    logic [7:0]            w_rd_lane [4];
    logic [31:0]           w_ram_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;

    assign w_accept = (r_state == S_IDLE) && (mem_rd_w_i_h || mem_wr_w_i_h);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= 3'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt   <= 4'(WAIT_STATES);
                r_addr  <= mem_addr_w_i;
                r_wdata <= mem_data_w_i;
                r_size  <= mem_size_w_i;
                r_rd    <= mem_rd_w_i_h;
                r_wr    <= mem_wr_w_i_h;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Legality is judged only on the values captured at acceptance.
    always_comb begin
        w_size_ok = 1'b0;
        case (r_size)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_size_ok = 1'b1;
            default:                                 w_size_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_align_ok = 1'b0;
        case (r_size[1:0])
            2'b00:   w_align_ok = 1'b1;
            2'b01:   w_align_ok = ~r_addr[0];
            2'b10:   w_align_ok = (r_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
    end

    assign w_range_ok = (r_addr[31:ADDR_WIDTH+2] == '0);
    assign w_legal    = w_size_ok && w_align_ok && w_range_ok
                        && !(r_rd && r_wr) && !(r_wr && r_size[2]);

    // While idle the read port follows the incoming address so data is ready for ACCESS
    // even with zero wait states.
    assign w_rd_idx = (r_state == S_IDLE) ? mem_addr_w_i[ADDR_WIDTH+1:2]
                                          : r_addr[ADDR_WIDTH+1:2];
    assign w_wr_idx = r_addr[ADDR_WIDTH+1:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane_mem [DEPTH];
            logic [7:0] r_lane_q;

            always_comb begin
                w_lane_sel[gi] = 1'b0;
                w_wlane[gi]    = 8'd0;
                case (r_size[1:0])
                    2'b00: begin
                        w_lane_sel[gi] = (r_addr[1:0] == 2'(gi));
                        w_wlane[gi]    = r_wdata[7:0];
                    end
                    2'b01: begin
                        w_lane_sel[gi] = (r_addr[1] == ((gi / 2) != 0));
                        w_wlane[gi]    = r_wdata[8*(gi%2) +: 8];
                    end
                    2'b10: begin
                        w_lane_sel[gi] = 1'b1;
                        w_wlane[gi]    = r_wdata[8*gi +: 8];
                    end
                    default: begin
                        w_lane_sel[gi] = 1'b0;
                        w_wlane[gi]    = 8'd0;
                    end
                endcase
            end

            assign w_we[gi] = (r_state == S_ACCESS) && w_legal && r_wr && w_lane_sel[gi];

            always_ff @(posedge clk_w_i) begin
                if (w_we[gi]) begin
                    r_lane_mem[w_wr_idx] <= w_wlane[gi];
                end
                r_lane_q <= r_lane_mem[w_rd_idx];
            end

            assign w_rd_lane[gi] = r_lane_q;
        end
    endgenerate

    assign w_ram_word = {w_rd_lane[3], w_rd_lane[2], w_rd_lane[1], w_rd_lane[0]};
    assign w_byte     = w_ram_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half     = w_ram_word[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load = 32'd0;
        case (r_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            3'b010:  w_load = w_ram_word;
            default: w_load = 32'd0;
        endcase
    end

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            mem_data_w_o    <= 32'd0;
            mem_ready_w_o_h <= 1'b0;
            mem_err_w_o_h   <= 1'b0;
        end else begin
            mem_ready_w_o_h <= (r_state == S_ACCESS);
            mem_err_w_o_h   <= (r_state == S_ACCESS) && !w_legal;
            mem_data_w_o    <= ((r_state == S_ACCESS) && w_legal && r_rd) ? w_load : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (0, 1 and 15 wait states) checked against a
// byte-addressed reference model through a response scoreboard.
module tb_data_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [2:0]  size  [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 1 : 15);
            data_mem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) u_dut (
                .clk_w_i        (clk),
                .res_w_i_l      (rst_n),
                .mem_addr_w_i   (addr[gi]),
                .mem_data_w_i   (wdata[gi]),
                .mem_wr_w_i_h   (wr[gi]),
                .mem_rd_w_i_h   (rd[gi]),
                .mem_size_w_i   (size[gi]),
                .mem_data_w_o   (rdata[gi]),
                .mem_ready_w_o_h(ready[gi]),
                .mem_err_w_o_h  (err[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic [1:0]  k;
        logic        r;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] res;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mbytes [3][64];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic int ws(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 15);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Byte-granular reference: size -> byte count, legality by plain arithmetic.
    function automatic void model(input int k, input logic r, input logic w, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic e, output logic [31:0] res);
        int     nb;
        longint v;
        nb = 0;
        case (sz)
            3'b000, 3'b100: nb = 1;
            3'b001, 3'b101: nb = 2;
            3'b010:         nb = 4;
            default:        nb = 0;
        endcase
        if (nb == 0) e = 1'b1;
        else e = (r && w) || (w && sz[2]) || ((a % nb) != 0) || (a >= 32'd4096);
        res = 32'd0;
        if (!e && w) begin
            for (int i = 0; i < nb; i++) mbytes[k][int'(a) + i] = d[8*i +: 8];
        end
        if (!e && r) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(mbytes[k][int'(a) + i]) << (8 * i));
            if (!sz[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            res = v[31:0];
        end
    endfunction

    // Monitor: every ready pulse pops one expected response.
    always @(negedge clk) begin
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            if (ready[k] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: inst %0d got a ready pulse, expected none", k);
                end else begin
                    x = sb_q.pop_front();
                    $display("inst %0d rd=%0d wr=%0d size=%0d addr=%08h wdata=%08h -> err=%0d data=%08h (exp err=%0d data=%08h)",
                             k, x.r, x.w, x.sz, x.a, x.d, err[k], rdata[k], x.e, x.res);
                    check("resp_inst", 32'(k), 32'(x.k));
                    check("resp_err", 32'(err[k]), 32'(x.e));
                    check("resp_data", rdata[k], x.res);
                end
            end
        end
    end

    task automatic issue(input int k, input logic r, input logic w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d, output int lat);
        exp_t x;
        logic e;
        logic [31:0] res;
        model(k, r, w, sz, a, d, e, res);
        x.k = 2'(k); x.r = r; x.w = w; x.sz = sz; x.a = a; x.d = d; x.e = e; x.res = res;
        sb_q.push_back(x);
        addr[k] = a; wdata[k] = d; size[k] = sz; rd[k] = r; wr[k] = w;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ready[k] !== 1'b1 && lat < 40);
        if (ready[k] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: inst %0d no ready within %0d cycles", k, lat);
        end
    endtask

    task automatic drop(input int k);
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", 32'(ready[k]), 32'd0);
    endtask

    // Isolated request: latency counted in edges after strobes are applied.
    task automatic txn(input int k, input logic r, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        int lat;
        issue(k, r, w, sz, a, d, lat);
        check("latency", 32'(lat), 32'(ws(k) + 2));
        drop(k);
    endtask

    task automatic rand_req(input bit legal_only, output logic r, output logic w,
                            output logic [2:0] sz, output logic [31:0] a, output logic [31:0] d);
        int nb;
        case ($urandom_range(0, 4))
            0: begin sz = 3'b000; nb = 1; end
            1: begin sz = 3'b001; nb = 2; end
            2: begin sz = 3'b010; nb = 4; end
            3: begin sz = 3'b100; nb = 1; end
            default: begin sz = 3'b101; nb = 2; end
        endcase
        w = 1'($urandom_range(0, 1));
        if (legal_only && sz[2]) w = 1'b0;
        r = ~w;
        a = 32'($urandom_range(0, 63));
        a = a - (a % nb);
        d = $urandom;
        if (!legal_only && $urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 3))
                0: sz = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b110;
                1: begin r = 1'b1; w = 1'b1; end
                2: a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
                default: if (nb > 1) a = a + 1; else a = 32'h8000_0000;
            endcase
        end
    endtask

    task automatic b2b(input int k, input int n);
        logic r, w;
        logic [2:0] sz;
        logic [31:0] a, d;
        int lat;
        for (int i = 0; i < n; i++) begin
            rand_req(1'b1, r, w, sz, a, d);
            issue(k, r, w, sz, a, d, lat);
            check("b2b_spacing", 32'(lat), 32'((i == 0) ? ws(k) + 2 : ws(k) + 3));
        end
        drop(k);
    endtask

    initial begin
        logic r, w;
        logic [2:0] sz;
        logic [31:0] a, d;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = 32'd0; wdata[k] = 32'd0; size[k] = 3'd0; rd[k] = 1'b0; wr[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", 32'(ready[k]), 32'd0);
            check("reset_err", 32'(err[k]), 32'd0);
            check("reset_data", rdata[k], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) txn(k, 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom);

        // Basic store/load round trip and lane behaviour.
        txn(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        txn(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        txn(1, 1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080);
        txn(1, 1'b0, 1'b1, 3'b001, 32'h10, 32'h0000_1234);
        txn(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        txn(1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        txn(1, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        txn(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h8001_0000);
        txn(1, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        txn(1, 1'b1, 1'b0, 3'b101, 32'h12, 32'h0);

        // Reset during WAIT discards a pending store.
        addr[1] = 32'h10; wdata[1] = 32'h1234_5678; size[1] = 3'b010; wr[1] = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        wr[1] = 1'b0;
        @(negedge clk);
        check("midreset_ready", 32'(ready[1]), 32'd0);
        check("midreset_err", 32'(err[1]), 32'd0);
        check("midreset_data", rdata[1], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        txn(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);

        // Illegal requests, then re-reads showing memory untouched.
        txn(1, 1'b1, 1'b0, 3'b010, 32'h2, 32'h0);
        txn(1, 1'b1, 1'b0, 3'b001, 32'h1, 32'h0);
        txn(1, 1'b0, 1'b1, 3'b010, 32'h1000, 32'hFFFF_FFFF);
        txn(1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        txn(1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h5555_AAAA);
        txn(1, 1'b0, 1'b1, 3'b100, 32'h10, 32'h0000_00AA);
        txn(1, 1'b0, 1'b1, 3'b010, 32'h0, 32'hFFFF_FFFF);
        txn(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        txn(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);

        // Back-to-back with strobes held through RESP.
        b2b(0, 6);
        b2b(2, 3);
        b2b(1, 4);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 25; i++) begin
                rand_req(1'b0, r, w, sz, a, d);
                txn(k, r, w, sz, a, d);
            end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
